mips_mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single data-memory port between the pipelined MIPS CPU (X-stage load/store access) and a DMA/accelerator master. It sits between the CPU's data-memory outputs and the synchronous data RAM. It selects one owner per cycle and stalls the CPU pipeline when the DMA wins. It also preserves CPU load data across such stalls, so the M stage always sees its own read result.

---
 rtl/mips_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Data-memory port arbiter between the pipelined MIPS CPU and a DMA master.
// CPU has priority; a starvation counter forces a DMA grant after MAX_WAIT denials.
module mips_mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_we,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    // Any byte lane enabled means the access is a store.
    function automatic logic any_lane(input logic [3:0] we);
        any_lane = |we;
    endfunction

    owner_e      owner_s;
    logic        cpu_req_s;
    logic        starve_max_s;
    logic [3:0]  starve_r;
    logic [3:0]  starve_nxt_s;
    logic        dma_rd_r;
    logic        cpu_rd_r;
    logic [31:0] cpu_hold_r;

    assign cpu_req_s    = cpu_re | any_lane(cpu_we);
    assign starve_max_s = (starve_r == MAX_WAIT_C);

    // Owner selection: CPU first unless the DMA has waited MAX_WAIT cycles.
    always_comb begin
        owner_s = OWN_NONE;
        if (dma_req && (!cpu_req_s || starve_max_s)) begin
            owner_s = OWN_DMA;
        end else if (cpu_req_s) begin
            owner_s = OWN_CPU;
        end else begin
            owner_s = OWN_NONE;
        end
    end

    // Memory port multiplexer driven from the current owner.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 4'b0000;
        mem_re    = 1'b0;
        case (owner_s)
            OWN_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_we    = dma_we;
                mem_re    = !any_lane(dma_we);
            end
            OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
                mem_re    = cpu_re;
            end
            default: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = 4'b0000;
                mem_re    = 1'b0;
            end
        endcase
    end

    // Starvation count: cleared by a grant or an idle DMA, saturates at MAX_WAIT.
    always_comb begin
        starve_nxt_s = starve_r;
        if ((owner_s == OWN_DMA) || !dma_req) begin
            starve_nxt_s = 4'd0;
        end else if (starve_r >= MAX_WAIT_C) begin
            starve_nxt_s = MAX_WAIT_C;
        end else begin
            starve_nxt_s = starve_r + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_r <= 4'd0;
        end else begin
            starve_r <= starve_nxt_s;
        end
    end

    // Remember which requester owns the read data returning next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_rd_r <= 1'b0;
            cpu_rd_r <= 1'b0;
        end else begin
            dma_rd_r <= (owner_s == OWN_DMA) && !any_lane(dma_we);
            cpu_rd_r <= (owner_s == OWN_CPU) && cpu_re;
        end
    end

    // Capture CPU load data so it survives later DMA-induced stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_hold_r <= 32'h0000_0000;
        end else if (cpu_rd_r) begin
            cpu_hold_r <= mem_rdata;
        end else begin
            cpu_hold_r <= cpu_hold_r;
        end
    end

    assign dma_gnt    = (owner_s == OWN_DMA);
    assign cpu_stall  = cpu_req_s && (owner_s == OWN_DMA);
    assign dma_rvalid = dma_rd_r;
    assign dma_rdata  = mem_rdata;
    assign cpu_rdata  = cpu_rd_r ? mem_rdata : cpu_hold_r;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter with a behavioural synchronous RAM
// and queue-based scoreboards for CPU and DMA read returns.
module tb_mips_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_we;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:1023];
    logic [31:0] cpu_q [$];
    logic [31:0] dma_q [$];
    logic [31:0] hold_exp;
    int n_checks;
    int n_fail;

    mips_mem_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM: one-cycle read latency, byte writes only in the low 4 KiB.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram[mem_addr[11:2]];
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b] && (mem_addr[31:12] == 20'h0)) ram[mem_addr[11:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_0200: return 32'h0BAD_F00D;
            32'h0000_0300: return 32'h1234_5678;
            32'h0000_0400: return 32'hCAFE_F00D;
            default:       return 32'h0000_0000;
        endcase
    endfunction

    task automatic idle_inputs();
        cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_we = 4'b0000; cpu_re = 1'b0;
        dma_req = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0; dma_we = 4'b0000;
    endtask

    task automatic test_reset();
        logic exp_gnt;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_addr  = $urandom() | 32'h8000_0000;
            cpu_wdata = $urandom();
            cpu_we    = 4'($urandom_range(0, 15));
            cpu_re    = 1'($urandom_range(0, 1));
            dma_req   = 1'($urandom_range(0, 1));
            dma_addr  = $urandom() | 32'h8000_0000;
            dma_wdata = $urandom();
            dma_we    = 4'($urandom_range(0, 15));
            #1;
            exp_gnt = dma_req & ~(cpu_re | (|cpu_we));
            n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", dma_rvalid); end
            n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata); end
            n_checks++; if (dma_gnt !== exp_gnt) begin n_fail++; $display("FAIL reset_dma_gnt: got %b expected %b", dma_gnt, exp_gnt); end
            n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL release_cpu_rdata: got %h expected 0", cpu_rdata); end
        hold_exp = 32'h0;
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        cpu_re = 1'b1; cpu_addr = 32'h300;
        #1;
        n_checks++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL mid_mem_re: got %b expected 1", mem_re); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (cpu_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL mid_before_rst: got %h expected 12345678", cpu_rdata); end
        rst = 1'b0;
        #1;
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_async_rst: got %h expected 0", cpu_rdata); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_dropped: got %h expected 0", cpu_rdata); end
        hold_exp = 32'h0;
    endtask

    task automatic test_cpu_only();
        @(negedge clk);
        cpu_re = 1'b1; cpu_addr = 32'h100;
        #1;
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_stall: got %b expected 0", cpu_stall); end
        n_checks++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL cpu_mem_re: got %b expected 1", mem_re); end
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL cpu_mem_addr: got %h expected 100", mem_addr); end
        cpu_q.push_back(exp_word(32'h100));
        @(negedge clk);
        idle_inputs();
        #1;
        hold_exp = cpu_q.pop_front();
        n_checks++; if (cpu_rdata !== hold_exp) begin n_fail++; $display("FAIL cpu_rdata: got %h expected %h", cpu_rdata, hold_exp); end
        @(negedge clk);
        #1;
        n_checks++; if (cpu_rdata !== hold_exp) begin n_fail++; $display("FAIL cpu_hold: got %h expected %h", cpu_rdata, hold_exp); end
    endtask

    task automatic test_dma_only();
        logic [31:0] e;
        @(negedge clk);
        dma_req = 1'b1; dma_addr = 32'h200; dma_we = 4'b0000;
        #1;
        n_checks++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dma_gnt: got %b expected 1", dma_gnt); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL dma_stall: got %b expected 0", cpu_stall); end
        n_checks++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL dma_mem_re: got %b expected 1", mem_re); end
        n_checks++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL dma_mem_addr: got %h expected 200", mem_addr); end
        dma_q.push_back(exp_word(32'h200));
        @(negedge clk);
        idle_inputs();
        #1;
        e = dma_q.pop_front();
        n_checks++; if (dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL dma_rvalid: got %b expected 1", dma_rvalid); end
        n_checks++; if (dma_rdata !== e) begin n_fail++; $display("FAIL dma_rdata: got %h expected %h", dma_rdata, e); end
        n_checks++; if (cpu_rdata !== hold_exp) begin n_fail++; $display("FAIL dma_cpu_hold: got %h expected %h", cpu_rdata, hold_exp); end
        @(negedge clk);
        #1;
        n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dma_rvalid_off: got %b expected 0", dma_rvalid); end
    endtask

    task automatic test_contention();
        logic prev_dma, prev_cpu, exp_dma;
        logic [31:0] e;
        prev_dma = 1'b0; prev_cpu = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c <= 15) begin
                cpu_re = 1'b1; cpu_addr = 32'h100; dma_req = 1'b1; dma_addr = 32'h200; dma_we = 4'b0000;
            end else begin
                idle_inputs();
            end
            #1;
            if (prev_dma) begin
                e = dma_q.pop_front();
                n_checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== e) begin n_fail++; $display("FAIL cont_dma_ret c%0d: got %b/%h expected 1/%h", c, dma_rvalid, dma_rdata, e); end
            end else begin
                n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL cont_rvalid c%0d: got %b expected 0", c, dma_rvalid); end
            end
            if (prev_cpu) hold_exp = cpu_q.pop_front();
            n_checks++; if (cpu_rdata !== hold_exp) begin n_fail++; $display("FAIL cont_cpu_rdata c%0d: got %h expected %h", c, cpu_rdata, hold_exp); end
            if (c <= 15) begin
                exp_dma = (c % 5 == 0);
                n_checks++; if (dma_gnt !== exp_dma) begin n_fail++; $display("FAIL cont_gnt c%0d: got %b expected %b", c, dma_gnt, exp_dma); end
                n_checks++; if (cpu_stall !== exp_dma) begin n_fail++; $display("FAIL cont_stall c%0d: got %b expected %b", c, cpu_stall, exp_dma); end
                n_checks++; if (mem_addr !== (exp_dma ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL cont_addr c%0d: got %h", c, mem_addr); end
                if (exp_dma) dma_q.push_back(exp_word(32'h200));
                else cpu_q.push_back(exp_word(32'h100));
                prev_dma = exp_dma; prev_cpu = !exp_dma;
            end
        end
    endtask

    task automatic test_load_across_stall();
        logic prev_dma, prev_cpu, exp_dma;
        logic [31:0] e;
        prev_dma = 1'b0; prev_cpu = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle_inputs();
            exp_dma = 1'b0;
            case (i)
                0, 1, 2: begin cpu_re = 1'b1; cpu_addr = 32'h100; dma_req = 1'b1; dma_addr = 32'h400; end
                3:       begin cpu_re = 1'b1; cpu_addr = 32'h300; dma_req = 1'b1; dma_addr = 32'h400; end
                4:       begin cpu_re = 1'b1; cpu_addr = 32'h100; dma_req = 1'b1; dma_addr = 32'h400; exp_dma = 1'b1; end
                5:       begin cpu_re = 1'b1; cpu_addr = 32'h100; end
                default: idle_inputs();
            endcase
            #1;
            if (prev_dma) begin
                e = dma_q.pop_front();
                n_checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== e) begin n_fail++; $display("FAIL las_dma_ret i%0d: got %b/%h expected 1/%h", i, dma_rvalid, dma_rdata, e); end
            end else begin
                n_checks++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL las_rvalid i%0d: got %b expected 0", i, dma_rvalid); end
            end
            if (prev_cpu) hold_exp = cpu_q.pop_front();
            n_checks++; if (cpu_rdata !== hold_exp) begin n_fail++; $display("FAIL las_cpu_rdata i%0d: got %h expected %h", i, cpu_rdata, hold_exp); end
            n_checks++; if (dma_gnt !== exp_dma) begin n_fail++; $display("FAIL las_gnt i%0d: got %b expected %b", i, dma_gnt, exp_dma); end
            n_checks++; if (cpu_stall !== exp_dma) begin n_fail++; $display("FAIL las_stall i%0d: got %b expected %b", i, cpu_stall, exp_dma); end
            if (exp_dma) dma_q.push_back(exp_word(dma_addr));
            if (!exp_dma && cpu_re) cpu_q.push_back(exp_word(cpu_addr));
            prev_dma = exp_dma; prev_cpu = !exp_dma && cpu_re;
        end
        n_checks++; if (hold_exp !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL las_final_order: got %h expected deadbeef", hold_exp); end
    endtask

    task automatic test_byte_store();
        @(negedge clk);
        cpu_we = 4'b0010; cpu_addr = 32'h500; cpu_wdata = 32'hAAAA_AAAA;
        dma_req = 1'b1; dma_addr = 32'h500; dma_we = 4'b0001; dma_wdata = 32'h0000_00EE;
        #1;
        n_checks++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL bs_a_gnt: got %b expected 0", dma_gnt); end
        n_checks++; if (mem_we !== 4'b0010 || mem_wdata !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL bs_a_cpu: got %b/%h expected 0010/aaaaaaaa", mem_we, mem_wdata); end
        @(negedge clk);
        cpu_we = 4'b0000; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        #1;
        n_checks++; if (dma_gnt !== 1'b1 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL bs_a_dma_gnt: got %b/%b expected 1/0", dma_gnt, cpu_stall); end
        n_checks++; if (mem_we !== 4'b0001 || mem_wdata !== 32'h0000_00EE || mem_re !== 1'b0) begin n_fail++; $display("FAIL bs_a_dma: got %b/%h/%b expected 0001/000000ee/0", mem_we, mem_wdata, mem_re); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            idle_inputs();
            cpu_re = 1'b1; cpu_addr = 32'h100;
            dma_req = 1'b1; dma_addr = 32'h504; dma_we = 4'b1000; dma_wdata = 32'hBB00_0000;
            #1;
            n_checks++; if (dma_gnt !== 1'b0 || mem_we !== 4'b0000) begin n_fail++; $display("FAIL bs_b_wait c%0d: got %b/%b expected 0/0000", c, dma_gnt, mem_we); end
        end
        @(negedge clk);
        cpu_re = 1'b0; cpu_we = 4'b0010; cpu_addr = 32'h504; cpu_wdata = 32'hCCCC_CCCC;
        #1;
        n_checks++; if (dma_gnt !== 1'b1 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL bs_b_force: got %b/%b expected 1/1", dma_gnt, cpu_stall); end
        n_checks++; if (mem_we !== 4'b1000 || mem_wdata !== 32'hBB00_0000) begin n_fail++; $display("FAIL bs_b_dma: got %b/%h expected 1000/bb000000", mem_we, mem_wdata); end
        @(negedge clk);
        dma_req = 1'b0; dma_we = 4'b0000;
        #1;
        n_checks++; if (cpu_stall !== 1'b0 || mem_we !== 4'b0010 || mem_wdata !== 32'hCCCC_CCCC) begin n_fail++; $display("FAIL bs_b_cpu: got %b/%b/%h expected 0/0010/cccccccc", cpu_stall, mem_we, mem_wdata); end
        @(negedge clk);
        idle_inputs();
        cpu_re = 1'b1; cpu_addr = 32'h504;
        #1;
        cpu_q.push_back(32'hBB00_CC00);
        @(negedge clk);
        idle_inputs();
        #1;
        hold_exp = cpu_q.pop_front();
        n_checks++; if (cpu_rdata !== hold_exp) begin n_fail++; $display("FAIL bs_b_readback: got %h expected %h", cpu_rdata, hold_exp); end
        n_checks++; if (ram[10'h140] !== 32'h1122_AAEE) begin n_fail++; $display("FAIL bs_a_ram: got %h expected 1122aaee", ram[10'h140]); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        hold_exp = 32'h0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[32'h100 >> 2] = 32'hDEAD_BEEF;
        ram[32'h200 >> 2] = 32'h0BAD_F00D;
        ram[32'h300 >> 2] = 32'h1234_5678;
        ram[32'h400 >> 2] = 32'hCAFE_F00D;
        ram[32'h500 >> 2] = 32'h1122_3344;
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_reset_mid_access();
        test_cpu_only();
        test_dma_only();
        test_contention();
        test_load_across_stall();
        test_byte_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
